// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset PC, icache address field widths,
// fetch FSM encoding and the instruction-buffer entry layout.
package cpu_pkg;

  localparam int PC_W     = 64;
  localparam int INST_W   = 32;
  localparam int IC_TAG_W = 23;
  localparam int IC_IDX_W = 6;
  localparam int IC_OFF_W = 3;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fifo_entry_t;

  // Instructions are word aligned; the two low PC bits are always forced to zero.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return a & ~64'h3;
  endfunction

endpackage

// File: rtl/ifu_inst_fifo.sv
// Synchronous instruction buffer holding {pc, inst} pairs between the icache
// and decode. Flush empties it in one edge; storage itself is never reset.
module ifu_inst_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fifo_entry_t      wdata,
  output fifo_entry_t      rdata,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Entry storage: written on push, no reset needed since count gates validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; flush discards everything regardless of push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one icache word request at a
// time, buffers returned words with their PCs and hands them to decode.
// Redirects flush the buffer and squash any request already accepted.
module ifu_fetch
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic                ic_valid,
  output logic [IC_TAG_W-1:0] ic_tag,
  output logic [IC_IDX_W-1:0] ic_index,
  output logic [IC_OFF_W-1:0] ic_offset,
  input  logic                ic_addr_ok,
  input  logic                ic_data_ok,
  input  logic [INST_W-1:0]   ic_rdata,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [PC_W-1:0]     id_pc,
  output logic [INST_W-1:0]   id_inst
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t     state, state_nxt;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  req_pc;
  logic             drop;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after;
  logic             accepted;
  logic             returning;
  logic             push;
  logic             pop;
  logic             credit;
  fifo_entry_t      wentry;
  fifo_entry_t      head;

  assign accepted  = (state == S_REQ)  && ic_addr_ok;
  assign returning = (state == S_WAIT) && ic_data_ok;
  assign push      = returning && !drop && !redirect_valid;
  assign pop       = id_valid && id_ready && !redirect_valid;

  // Occupancy as it will be after this edge; a request may only be issued
  // when that leaves room for the word it brings back.
  always_comb begin
    count_after = count;
    if (push)           count_after = count_after + CNT_W'(1);
    if (pop)            count_after = count_after - CNT_W'(1);
    if (redirect_valid) count_after = '0;
  end

  assign credit = count_after < CNT_W'(FIFO_DEPTH);

  // Fetch FSM next state; a redirect never changes state, only pc and drop.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (credit)     state_nxt = S_REQ;
      S_REQ:   if (ic_addr_ok) state_nxt = S_WAIT;
      S_WAIT:  if (ic_data_ok) state_nxt = credit ? S_REQ : S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, fetch PC and the squash flag for an in-flight word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) pc <= align_pc(redirect_pc);
      else if (accepted)  pc <= pc + 64'd4;
      // The returning word always clears drop; a redirect alongside it
      // discards that word directly so nothing is left to squash.
      if (returning) drop <= 1'b0;
      else if (redirect_valid && (accepted || state == S_WAIT)) drop <= 1'b1;
    end
  end

  // PC of the request the icache is currently serving.
  always_ff @(posedge clk) begin
    if (accepted) req_pc <= pc;
  end

  assign wentry.pc   = req_pc;
  assign wentry.inst = ic_rdata;

  ifu_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

  assign ic_valid  = (state == S_REQ);
  assign ic_tag    = pc[31:9];
  assign ic_index  = pc[8:3];
  assign ic_offset = pc[2:0];

  assign id_valid  = (count != '0);
  assign id_pc     = id_valid ? head.pc   : '0;
  assign id_inst   = id_valid ? head.inst : '0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: an icache responder with random latency, a PC-sequence
// reference model feeding a scoreboard queue, a redirect-field vector table and
// hand-written reset/redirect corner sequences followed by a random soak.
module tb_ifu_fetch;
  import cpu_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ic_valid;
  logic [22:0] ic_tag;
  logic [5:0]  ic_index;
  logic [2:0]  ic_offset;
  logic        ic_addr_ok;
  logic        ic_data_ok;
  logic [31:0] ic_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_inst;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ic_valid(ic_valid), .ic_tag(ic_tag), .ic_index(ic_index), .ic_offset(ic_offset),
    .ic_addr_ok(ic_addr_ok), .ic_data_ok(ic_data_ok), .ic_rdata(ic_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst)
  );

  typedef struct { logic [63:0] pc; logic [31:0] inst; } exp_t;
  typedef struct {
    logic [63:0] rpc; logic [22:0] tag; logic [5:0] idx; logic [2:0] off;
    logic [63:0] pc1; logic [63:0] pc2;
  } vec_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  bit          pending;
  int          cd;
  logic [31:0] p_addr;
  logic [63:0] p_pc;
  int          p_epoch;
  int          epoch = 0;
  logic [63:0] model_pc = RST_PC;
  bit          accept_en;
  bit          force_stale;
  int          lat_min = 1;
  int          lat_max = 1;
  int          pops = 0;
  logic [63:0] last_pop_pc;
  bit          cap_ic_valid, cap_id_valid;
  logic [31:0] cap_addr;
  logic [63:0] cap_id_pc;

  // Memory image; the reset-vector word is 0x00000413.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] ^ 32'h8000_0413) ^ {a[17:2], 16'h0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // One clock: observe DUT at negedge, retire pops, drive icache/decode/redirect.
  task automatic tick(input bit rdy, input bit redir, input logic [63:0] rpc);
    exp_t e;
    @(negedge clk);
    cap_ic_valid = ic_valid;
    cap_addr     = {ic_tag, ic_index, ic_offset};
    cap_id_valid = id_valid;
    cap_id_pc    = id_pc;
    chk("fifo_occupancy", 64'(id_valid), 64'(q.size() != 0));
    if (pending) chk("single_outstanding", 64'(ic_valid), 64'd0);
    id_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
    if (id_valid && rdy && !redir && q.size() != 0) begin
      e = q.pop_front();
      chk("id_pc", id_pc, e.pc);
      chk("id_inst", 64'(id_inst), 64'(e.inst));
      pops++;
      last_pop_pc = id_pc;
    end
    ic_addr_ok = 1'b0; ic_data_ok = 1'b0; ic_rdata = 32'h0;
    if (force_stale) begin
      ic_data_ok = 1'b1; ic_rdata = 32'hDEAD_BEEF;
    end else if (pending) begin
      if (cd == 0) begin
        ic_data_ok = 1'b1; ic_rdata = mem_word({32'h0, p_addr}); pending = 1'b0;
        if (p_epoch == epoch && !redir) begin
          e.pc = p_pc; e.inst = mem_word(p_pc); q.push_back(e);
        end
      end else cd--;
    end
    if (ic_valid && accept_en && !pending) begin
      ic_addr_ok = 1'b1; pending = 1'b1;
      cd = int'($urandom_range(lat_max, lat_min)) - 1;
      p_addr = cap_addr; p_epoch = epoch; p_pc = model_pc;
      if (!redir) begin
        chk("fetch_addr", 64'(cap_addr), 64'(model_pc[31:0]));
        model_pc = model_pc + 64'd4;
      end
    end
    if (redir) begin
      q.delete(); model_pc = rpc & ~64'h3; epoch++;
    end
  endtask

  // Asynchronous reset between edges, with immediate check of cleared outputs.
  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_ic_valid", 64'(ic_valid), 64'd0);
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_id_pc", id_pc, 64'd0);
    chk("rst_id_inst", 64'(id_inst), 64'd0);
    id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    ic_addr_ok = 1'b0; ic_data_ok = 1'b0; ic_rdata = '0;
    q.delete(); pending = 1'b0; epoch++; model_pc = RST_PC;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   n;
    int   p0;
    int   vcount;
    bit   rdy, redir;

    vecs[0] = '{64'h0000_0000_8000_1003, 23'h400008, 6'h00, 3'h0, 64'h8000_1000, 64'h8000_1004};
    vecs[1] = '{64'h0000_0000_8000_01FE, 23'h400000, 6'h3F, 3'h4, 64'h8000_01FC, 64'h8000_0200};
    vecs[2] = '{64'h0000_0000_8000_0204, 23'h400001, 6'h00, 3'h4, 64'h8000_0204, 64'h8000_0208};
    vecs[3] = '{64'h0000_0000_8000_ABC9, 23'h400055, 6'h39, 3'h0, 64'h8000_ABC8, 64'h8000_ABCC};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 23'h7FFFFF, 6'h3F, 3'h4, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};

    rst = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    ic_addr_ok = 1'b0; ic_data_ok = 1'b0; ic_rdata = '0;
    accept_en = 1'b0; force_stale = 1'b0; pending = 1'b0;

    // 1: first fetch after reset
    do_reset();
    accept_en = 1'b1; lat_min = 2; lat_max = 2;
    n = 0;
    do begin tick(1'b1, 1'b0, '0); n++; end while (!cap_ic_valid && n < 10);
    chk("t1_first_req_cycle", 64'(n), 64'd1);
    chk("t1_tag", 64'(cap_addr[31:9]), 64'h400000);
    chk("t1_index", 64'(cap_addr[8:3]), 64'h0);
    chk("t1_offset", 64'(cap_addr[2:0]), 64'h0);
    p0 = pops; n = 0;
    do begin tick(1'b1, 1'b0, '0); n++; end while (pops == p0 && n < 20);
    chk("t1_id_pc", last_pop_pc, 64'h8000_0000);
    chk("t1_id_inst", 64'(mem_word(last_pop_pc)), 64'h0000_0413);

    // 2: decode stalled, buffer fills to exactly two
    do_reset();
    accept_en = 1'b1; lat_min = 1; lat_max = 1; vcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0, '0);
      if (i >= 6 && cap_ic_valid) vcount++;
    end
    chk("t2_no_fetch_when_full", 64'(vcount), 64'd0);
    chk("t2_head_pc", cap_id_pc, 64'h8000_0000);
    tick(1'b1, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    chk("t2_second_valid", 64'(cap_id_valid), 64'd1);
    chk("t2_second_pc", cap_id_pc, 64'h8000_0004);
    chk("t2_refetch_valid", 64'(cap_ic_valid), 64'd1);
    chk("t2_refetch_addr", 64'(cap_addr), 64'h8000_0008);
    repeat (6) tick(1'b1, 1'b0, '0);

    // 3: redirect while a request is in flight and the buffer holds a word
    do_reset();
    accept_en = 1'b1; lat_min = 4; lat_max = 4; n = 0;
    do begin tick(1'b0, 1'b0, '0); n++; end while (!(q.size() == 1 && pending) && n < 20);
    chk("t3_setup", 64'(q.size() == 1 && pending), 64'd1);
    tick(1'b0, 1'b1, 64'h8000_1003);
    tick(1'b1, 1'b0, '0);
    chk("t3_flushed", 64'(cap_id_valid), 64'd0);
    n = 0;
    do begin tick(1'b1, 1'b0, '0); n++; end while (!cap_ic_valid && n < 10);
    chk("t3_tag", 64'(cap_addr[31:9]), 64'h400008);
    chk("t3_index", 64'(cap_addr[8:3]), 64'h0);
    chk("t3_offset", 64'(cap_addr[2:0]), 64'h0);
    p0 = pops; n = 0;
    do begin tick(1'b1, 1'b0, '0); n++; end while (pops == p0 && n < 20);
    chk("t3_id_pc", last_pop_pc, 64'h8000_1000);

    // 4: redirect in the same cycle as data_ok
    lat_min = 3; lat_max = 3; n = 0;
    do begin tick(1'b1, 1'b0, '0); n++; end while (!(pending && cd == 0) && n < 20);
    tick(1'b1, 1'b1, 64'h8000_2000);
    tick(1'b1, 1'b0, '0);
    chk("t4_reissue_valid", 64'(cap_ic_valid), 64'd1);
    chk("t4_reissue_addr", 64'(cap_addr), 64'h8000_2000);
    p0 = pops; n = 0;
    do begin tick(1'b1, 1'b0, '0); n++; end while (pops == p0 && n < 20);
    chk("t4_id_pc", last_pop_pc, 64'h8000_2000);

    // 5: reset mid-WAIT, stale data_ok after release must be ignored
    lat_min = 4; lat_max = 4; n = 0;
    do begin tick(1'b0, 1'b0, '0); n++; end while (!(q.size() == 1 && pending) && n < 20);
    do_reset();
    accept_en = 1'b0; force_stale = 1'b1;
    repeat (2) tick(1'b1, 1'b0, '0);
    force_stale = 1'b0; accept_en = 1'b1; lat_min = 2; lat_max = 2;
    p0 = pops; n = 0;
    do begin tick(1'b1, 1'b0, '0); n++; end while (pops == p0 && n < 20);
    chk("t5_id_pc", last_pop_pc, 64'h8000_0000);

    // Redirect field-slicing vectors
    for (int v = 0; v < 5; v++) begin
      accept_en = 1'b0; lat_min = 1; lat_max = 3; n = 0;
      while (pending && n < 10) begin tick(1'b1, 1'b0, '0); n++; end
      tick(1'b1, 1'b1, vecs[v].rpc);
      n = 0;
      do begin tick(1'b1, 1'b0, '0); n++; end while (!cap_ic_valid && n < 10);
      chk("vec_tag", 64'(cap_addr[31:9]), 64'(vecs[v].tag));
      chk("vec_index", 64'(cap_addr[8:3]), 64'(vecs[v].idx));
      chk("vec_offset", 64'(cap_addr[2:0]), 64'(vecs[v].off));
      accept_en = 1'b1; p0 = pops; n = 0;
      do begin tick(1'b1, 1'b0, '0); n++; end while (pops == p0 && n < 20);
      chk("vec_pc1", last_pop_pc, vecs[v].pc1);
      n = 0;
      do begin tick(1'b1, 1'b0, '0); n++; end while (pops == p0 + 1 && n < 20);
      chk("vec_pc2", last_pop_pc, vecs[v].pc2);
    end

    // 6: random stall/latency/redirect soak
    lat_min = 1; lat_max = 4; p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      accept_en = ($urandom_range(9, 0) < 8);
      rdy   = ($urandom_range(9, 0) < 7);
      redir = ($urandom_range(99, 0) < 3);
      tick(rdy, redir, {32'h0, 16'h8000, 16'($urandom)});
    end
    chk("soak_progress", 64'((pops - p0) > 100), 64'd1);
    accept_en = 1'b0; n = 0;
    do begin tick(1'b1, 1'b0, '0); n++; end while ((pending || q.size() != 0) && n < 50);
    chk("soak_drained", 64'(!pending && q.size() == 0), 64'd1);
    tick(1'b1, 1'b0, '0);
    chk("soak_empty_valid", 64'(cap_id_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
